// File: rtl/pipeline_cpu.sv
// Five-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with EX-stage forwarding,
// a one-cycle load-use stall and branch/jump resolution in ID.

module pc_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en,
    input  logic [31:0] pc_next,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)  pc_o <= '0;
        else if (en) pc_o <= pc_next;
endmodule

module instr_mem #(
    parameter int WORDS = 256
) (
    input  logic [$clog2(WORDS)-1:0] addr,
    output logic [31:0]              instr
);
    // Loaded from outside the core; there is no write port.
    logic [31:0] memory [0:WORDS-1];
    assign instr = memory[addr];
endmodule

module reg_file (
    input  logic        clk_i,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        we,
    input  logic [4:0]  wr,
    input  logic [31:0] wd,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk_i)
        if (we && wr != 5'd0) register[wr] <= wd;

    // Write-through lets ID see the value WB is committing this cycle.
    always_comb begin
        rs_data = register[rs];
        rt_data = register[rt];
        if (rs == 5'd0)              rs_data = '0;
        else if (we && wr == rs)     rs_data = wd;
        if (rt == 5'd0)              rt_data = '0;
        else if (we && wr == rt)     rt_data = wd;
    end
endmodule

module data_mem #(
    parameter int BYTES = 32
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(BYTES)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    localparam int AW = $clog2(BYTES);
    logic [7:0]    mem [0:BYTES-1];
    logic [AW-1:0] a1, a2, a3;

    // Byte lanes wrap modulo the memory size.
    assign a1 = addr + AW'(1);
    assign a2 = addr + AW'(2);
    assign a3 = addr + AW'(3);
    assign rdata = {mem[a3], mem[a2], mem[a1], mem[addr]};

    always_ff @(posedge clk_i)
        if (we) begin
            mem[addr] <= wdata[7:0];
            mem[a1]   <= wdata[15:8];
            mem[a2]   <= wdata[23:16];
            mem[a3]   <= wdata[31:24];
        end
endmodule

module mux2 (
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic        sel,
    output logic [31:0] data_o
);
    assign data_o = sel ? data1 : data0;
endmodule

module pipeline_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_BYTES);

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23,
                           OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_MUL = 6'h18;

    typedef struct packed {
        logic       reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write, mem_to_reg, mem_write;
        logic [31:0] alu, store;
        logic [4:0]  wr;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write, mem_to_reg;
        logic [31:0] alu, rdata;
        logic [4:0]  wr;
    } mem_wb_t;

    logic [31:0] pc, pc4, pc_next, instr, target;
    logic        pc_en, hazard, flush, take, branch, jump;
    logic [31:0] if_id_pc4, if_id_instr;
    id_ex_t      id_ex, id_ex_d;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;
    ctrl_t       id_ctrl;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_ex;
    logic [31:0] imm, rs_data, rt_data;
    logic [31:0] fwd_a, fwd_b, op_b, alu_res, rdata, wb_data;
    logic        wb_we;
    logic [4:0]  wb_wr;

    // ---------------- IF
    assign pc4     = pc + 32'd4;
    assign pc_en   = !hazard && (flush || start_i);
    assign pc_next = flush ? target : pc4;

    pc_reg PC (.clk_i(clk_i), .rst_i(rst_i), .en(pc_en), .pc_next(pc_next), .pc_o(pc));

    instr_mem #(.WORDS(IMEM_WORDS)) Instruction_Memory (.addr(pc[IAW+1:2]), .instr(instr));

    // With start low, IF/ID takes bubbles so the in-flight work drains.
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            if_id_pc4   <= '0;
            if_id_instr <= '0;
        end else if (!hazard) begin
            if (flush || !start_i) begin
                if_id_pc4   <= '0;
                if_id_instr <= '0;
            end else begin
                if_id_pc4   <= pc4;
                if_id_instr <= instr;
            end
        end

    // ---------------- ID
    assign op    = if_id_instr[31:26];
    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];
    assign rd    = if_id_instr[15:11];
    assign funct = if_id_instr[5:0];
    assign imm   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

    reg_file Registers (
        .clk_i(clk_i), .rs(rs), .rt(rt), .we(wb_we), .wr(wb_wr), .wd(wb_data),
        .rs_data(rs_data), .rt_data(rt_data)
    );

    always_comb begin
        id_ctrl = '0;
        branch  = 1'b0;
        jump    = 1'b0;
        case (op)
            OP_R: if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_MUL}) begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.reg_dst   = 1'b1;
                id_ctrl.alu_op    = 2'b10;
            end
            OP_ADDI: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                id_ctrl.mem_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                branch         = 1'b1;
                id_ctrl.alu_op = 2'b01;
            end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign take   = (branch && rs_data == rt_data) || jump;
    assign target = jump ? {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}
                         : if_id_pc4 + {imm[29:0], 2'b00};
    assign hazard = id_ex.ctrl.mem_read && id_ex.rt != 5'd0 &&
                    (id_ex.rt == rs || id_ex.rt == rt);
    // A stalled branch is re-evaluated next cycle, so it must not redirect now.
    assign flush  = take && !hazard;

    assign id_ex_d = '{ctrl: id_ctrl, rs_data: rs_data, rt_data: rt_data, imm: imm,
                       rs: rs, rt: rt, rd: rd, funct: funct};

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)      id_ex <= '0;
        else if (hazard) id_ex <= '0;
        else             id_ex <= id_ex_d;

    // ---------------- EX
    always_comb begin
        fwd_a = id_ex.rs_data;
        if (ex_mem.reg_write && ex_mem.wr != 5'd0 && ex_mem.wr == id_ex.rs)
            fwd_a = ex_mem.alu;
        else if (mem_wb.reg_write && mem_wb.wr != 5'd0 && mem_wb.wr == id_ex.rs)
            fwd_a = wb_data;
        fwd_b = id_ex.rt_data;
        if (ex_mem.reg_write && ex_mem.wr != 5'd0 && ex_mem.wr == id_ex.rt)
            fwd_b = ex_mem.alu;
        else if (mem_wb.reg_write && mem_wb.wr != 5'd0 && mem_wb.wr == id_ex.rt)
            fwd_b = wb_data;
    end

    assign op_b  = id_ex.ctrl.alu_src ? id_ex.imm : fwd_b;
    assign wr_ex = id_ex.ctrl.reg_dst ? id_ex.rd : id_ex.rt;

    always_comb begin
        alu_res = fwd_a + op_b;
        case (id_ex.ctrl.alu_op)
            2'b01: alu_res = fwd_a - op_b;
            2'b10: case (id_ex.funct)
                FN_ADD:  alu_res = fwd_a + op_b;
                FN_SUB:  alu_res = fwd_a - op_b;
                FN_AND:  alu_res = fwd_a & op_b;
                FN_OR:   alu_res = fwd_a | op_b;
                FN_MUL:  alu_res = fwd_a * op_b;
                default: alu_res = '0;
            endcase
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) ex_mem <= '0;
        else        ex_mem <= '{reg_write: id_ex.ctrl.reg_write, mem_to_reg: id_ex.ctrl.mem_to_reg,
                                mem_write: id_ex.ctrl.mem_write, alu: alu_res, store: fwd_b,
                                wr: wr_ex};

    // ---------------- MEM
    data_mem #(.BYTES(DMEM_BYTES)) Memory (
        .clk_i(clk_i), .we(ex_mem.mem_write), .addr(ex_mem.alu[DAW-1:0]),
        .wdata(ex_mem.store), .rdata(rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) mem_wb <= '0;
        else        mem_wb <= '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg,
                                alu: ex_mem.alu, rdata: rdata, wr: ex_mem.wr};

    // ---------------- WB
    mux2 MUX_MemtoReg (.data0(mem_wb.alu), .data1(mem_wb.rdata), .sel(mem_wb.mem_to_reg),
                       .data_o(wb_data));

    assign wb_we = mem_wb.reg_write;
    assign wb_wr = mem_wb.wr;
endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: preloads memories, runs short programs and
// scoreboards every register-file write against a queue of expected writes.

module tb_pipeline_cpu;
    logic clk_i, rst_i, start_i;

    pipeline_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [4:0]  r;
        logic [31:0] v;
    } wb_t;

    wb_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  hz_cnt = 0;
    int  fl_cnt = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic expect_wb(input logic [4:0] r, input logic [31:0] v);
        wb_t e;
        e.r = r;
        e.v = v;
        exp_q.push_back(e);
    endtask

    // Hold reset and wipe instruction memory; caller then loads a program.
    task automatic begin_test();
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        check("reset_pc_async", dut.PC.pc_o, 32'd0);
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        tick(1);
    endtask

    task automatic go();
        rst_i   = 1'b1;
        start_i = 1'b1;
        hz_cnt  = 0;
        fl_cnt  = 0;
    endtask

    // Commit monitor: every nonzero-register write must match the head of the queue.
    always @(negedge clk_i) begin
        if (dut.hazard === 1'b1) hz_cnt++;
        if (dut.flush === 1'b1)  fl_cnt++;
        if (dut.wb_we === 1'b1 && dut.wb_wr !== 5'd0) begin
            tests++;
            assert (exp_q.size() > 0)
            else begin
                fails++;
                $error("FAIL wb_unexpected: observed r%0d=0x%0h expected no write",
                       dut.wb_wr, dut.MUX_MemtoReg.data_o);
            end
            if (exp_q.size() > 0) begin
                wb_t e;
                e = exp_q.pop_front();
                tests++;
                assert ({dut.wb_wr, dut.MUX_MemtoReg.data_o} === {e.r, e.v})
                else begin
                    fails++;
                    $error("FAIL wb_data: observed r%0d=0x%0h expected r%0d=0x%0h",
                           dut.wb_wr, dut.MUX_MemtoReg.data_o, e.r, e.v);
                end
            end
        end
    end

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'd0;
        for (int i = 0; i < 32; i++)  dut.Memory.mem[i] = 8'd0;
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        dut.Registers.register[5] = 32'h55;
        dut.Memory.mem[0] = 8'd5;

        // ---- reset state, start gating, NOP stream
        tick(1);
        check("reset_pc", dut.PC.pc_o, 32'd0);
        check("reset_hazard", 32'(dut.hazard), 32'd0);
        check("reset_flush", 32'(dut.flush), 32'd0);
        rst_i = 1'b1;
        tick(2);
        check("start_low_hold", dut.PC.pc_o, 32'd0);
        start_i = 1'b1;
        hz_cnt = 0;
        fl_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check("pc_step", dut.PC.pc_o, 32'(4 * k));
        end
        check("nop_reg_kept", dut.Registers.register[5], 32'h55);
        check("nop_mem_kept", 32'(dut.Memory.mem[0]), 32'd5);
        check("nop_no_stall", 32'(hz_cnt), 32'd0);
        check("nop_no_flush", 32'(fl_cnt), 32'd0);

        // ---- load-use: lw $t0,0($0); addi $t1,$t0,3
        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd8, 5'd9, 16'd3);
        expect_wb(5'd8, 32'd5);
        expect_wb(5'd9, 32'd8);
        go();
        tick(10);
        check("lu_pc_one_hold", dut.PC.pc_o, 32'd36);
        check("lu_stall_count", 32'(hz_cnt), 32'd1);
        check("lu_t0", dut.Registers.register[8], 32'd5);
        check("lu_t1", dut.Registers.register[9], 32'd8);
        check("lu_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- back-to-back forwarding
        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd7);
        dut.Instruction_Memory.memory[1] = enc_r(5'd16, 5'd16, 5'd17, 6'h20);
        dut.Instruction_Memory.memory[2] = enc_r(5'd17, 5'd16, 5'd18, 6'h22);
        expect_wb(5'd16, 32'd7);
        expect_wb(5'd17, 32'd14);
        expect_wb(5'd18, 32'd7);
        go();
        tick(10);
        check("fw_s1", dut.Registers.register[17], 32'd14);
        check("fw_s2", dut.Registers.register[18], 32'd7);
        check("fw_no_stall", 32'(hz_cnt), 32'd0);
        check("fw_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- mul with negative operand, and/or (or reads via write-through)
        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd6);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
        dut.Instruction_Memory.memory[2] = enc_r(5'd8, 5'd9, 5'd10, 6'h18);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, 5'd0, 5'd11, 16'd12);
        dut.Instruction_Memory.memory[4] = enc_i(6'h08, 5'd0, 5'd12, 16'd10);
        dut.Instruction_Memory.memory[5] = enc_r(5'd11, 5'd12, 5'd13, 6'h24);
        dut.Instruction_Memory.memory[6] = enc_r(5'd11, 5'd12, 5'd14, 6'h25);
        expect_wb(5'd8, 32'd6);
        expect_wb(5'd9, 32'hFFFF_FFFD);
        expect_wb(5'd10, 32'hFFFF_FFEE);
        expect_wb(5'd11, 32'd12);
        expect_wb(5'd12, 32'd10);
        expect_wb(5'd13, 32'd8);
        expect_wb(5'd14, 32'd14);
        go();
        tick(14);
        check("alu_mul", dut.Registers.register[10], 32'hFFFF_FFEE);
        check("alu_and", dut.Registers.register[13], 32'd8);
        check("alu_or", dut.Registers.register[14], 32'd14);
        check("alu_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- beq $0,$0,+2 skips two addi
        begin_test();
        dut.Registers.register[8]  = 32'h77;
        dut.Registers.register[9]  = 32'h77;
        dut.Registers.register[10] = 32'h77;
        dut.Instruction_Memory.memory[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd2);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, 5'd0, 5'd10, 16'd3);
        expect_wb(5'd10, 32'd3);
        go();
        tick(2);
        check("beq_target", dut.PC.pc_o, 32'd12);
        tick(8);
        check("beq_pc_after", dut.PC.pc_o, 32'd44);
        check("beq_flush_count", 32'(fl_cnt), 32'd1);
        check("beq_skip1", dut.Registers.register[8], 32'h77);
        check("beq_skip2", dut.Registers.register[9], 32'h77);
        check("beq_taken_write", dut.Registers.register[10], 32'd3);
        check("beq_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- j to word 10
        begin_test();
        dut.Registers.register[12] = 32'h77;
        dut.Instruction_Memory.memory[0]  = {6'h02, 26'd10};
        dut.Instruction_Memory.memory[1]  = enc_i(6'h08, 5'd0, 5'd12, 16'd1);
        dut.Instruction_Memory.memory[10] = enc_i(6'h08, 5'd0, 5'd11, 16'h5A);
        expect_wb(5'd11, 32'h5A);
        go();
        tick(1);
        check("j_flush_high", 32'(dut.flush), 32'd1);
        tick(1);
        check("j_target", dut.PC.pc_o, 32'd40);
        check("j_flush_low", 32'(dut.flush), 32'd0);
        tick(8);
        check("j_pc_after", dut.PC.pc_o, 32'd72);
        check("j_flush_count", 32'(fl_cnt), 32'd1);
        check("j_skip", dut.Registers.register[12], 32'h77);
        check("j_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- sw little-endian, reload, address wrap
        begin_test();
        dut.Registers.register[8] = 32'h1122_3344;
        dut.Instruction_Memory.memory[0] = enc_i(6'h2B, 5'd0, 5'd8, 16'd4);
        dut.Instruction_Memory.memory[1] = enc_i(6'h23, 5'd0, 5'd9, 16'd4);
        dut.Instruction_Memory.memory[2] = enc_i(6'h23, 5'd0, 5'd10, 16'h24);
        expect_wb(5'd9, 32'd287454020);
        expect_wb(5'd10, 32'd287454020);
        go();
        tick(10);
        check("sw_b4", 32'(dut.Memory.mem[4]), 32'h44);
        check("sw_b5", 32'(dut.Memory.mem[5]), 32'h33);
        check("sw_b6", 32'(dut.Memory.mem[6]), 32'h22);
        check("sw_b7", 32'(dut.Memory.mem[7]), 32'h11);
        check("sw_word_reload", dut.Registers.register[9], 32'd287454020);
        check("lw_addr_wrap", dut.Registers.register[10], 32'd287454020);
        check("sw_no_stall", 32'(hz_cnt), 32'd0);
        check("sw_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- asynchronous reset mid-run
        begin_test();
        dut.Registers.register[16] = 32'h99;
        dut.Registers.register[17] = 32'h99;
        dut.Registers.register[18] = 32'h99;
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd7);
        dut.Instruction_Memory.memory[1] = enc_r(5'd16, 5'd16, 5'd17, 6'h20);
        dut.Instruction_Memory.memory[2] = enc_r(5'd17, 5'd16, 5'd18, 6'h22);
        expect_wb(5'd16, 32'd7);
        expect_wb(5'd17, 32'd14);
        go();
        tick(6);
        #1;
        rst_i = 1'b0;
        #1;
        check("mid_reset_pc", dut.PC.pc_o, 32'd0);
        check("mid_reset_ifid", dut.if_id_instr, 32'd0);
        check("mid_reset_idex_ctrl", 32'(dut.id_ex.ctrl), 32'd0);
        check("mid_reset_wb_we", 32'(dut.wb_we), 32'd0);
        tick(2);
        check("mid_reset_pc_held", dut.PC.pc_o, 32'd0);
        check("mid_reset_keep_s0", dut.Registers.register[16], 32'd7);
        check("mid_reset_keep_s1", dut.Registers.register[17], 32'd14);
        check("mid_reset_s2_untouched", dut.Registers.register[18], 32'h99);
        check("mid_reset_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_cpu.md
Name: pipeline_cpu

Overview:
- 32-bit, five-stage (IF/ID/EX/MEM/WB) in-order MIPS-subset processor and top-level design block.
- Contains these internal blocks:
  - PC register
  - 256-word instruction memory
  - 32×32 register file
  - 32-byte data memory
  - forwarding unit
  - load-use hazard detector
  - branch/jump flush logic
- Internal state is probed hierarchically by the bench, so the hierarchical names below are part of the interface.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_BYTES, 32, data memory size in bytes.

Ports:
- clk_i, input, 1, rising-edge clock.
- rst_i, input, 1, asynchronous active-low reset.
- start_i, input, 1, run enable; the PC advances only while high.

Behaviour:
- Required hierarchy names:
  - PC.pc_o: 32-bit current PC.
  - Instruction_Memory.memory[0:255]: 32-bit words.
  - Registers.register[0:31]: 32-bit.
  - Memory.mem[0:31]: 8-bit, little-endian; word at address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
  - MUX_MemtoReg.data_o: WB write data.
  - Top-level wires hazard (load-use stall) and flush (IF/ID flush).
- Reset (rst_i=0) clears:
  - PC to 0.
  - All pipeline registers to 0, i.e. NOP with all control signals deasserted.
  - hazard and flush to 0.
- Reset does not clear the register file or either memory; the bench preloads them.
- start_i=0: PC holds; the pipeline still clocks, so in-flight instructions drain.
- Instruction fetch: instr = memory[PC[9:2]]. Next PC = PC+4 unless stalled or redirected.
- Supported ISA, MIPS encodings; any other opcode executes as a NOP:
  - R-type (op 0): add (funct 0x20), sub (0x22), and (0x24), or (0x25), mul (0x18, low 32 bits of the product). Destination is rd.
  - addi (op 0x08): sign-extended imm16; destination rt.
  - lw (op 0x23), sw (op 0x2B): address = rs + sext(imm); word access, little-endian.
  - beq (op 0x04): target = PC+4 + (sext(imm)<<2).
  - j (op 0x02): target = {PC+4[31:28], addr26, 2'b00}.
- Writes to R0 are ignored; R0 always reads 0.
- The register file writes on the clock edge and reads combinationally with write-through: a same-cycle WB write to the read register returns the new data.
- Branch and jump resolve in ID:
  - beq compares the raw register-file operands. There is no forwarding into ID; software inserts spacing.
  - When taken (or for any j), the PC loads the target, the IF/ID register is zeroed, and flush=1 for that cycle.
  - Cost is one bubble, with no delay slot.
- Forwarding into EX, for each of rs and rt:
  - From EX/MEM when RegWrite && rd≠0 && rd matches.
  - Otherwise from MEM/WB under the same conditions.
  - EX/MEM takes priority.
  - The sw store data uses the forwarded rt.
- Load-use hazard: the ID/EX instruction is lw with rt equal to IF/ID rs or rt (rt≠0). Then:
  - hazard=1.
  - PC and IF/ID hold.
  - ID/EX control is zeroed (a bubble is inserted).
  - Penalty is one cycle.
- If stall and branch are both asserted in the same cycle, stall wins. The branch re-evaluates the next cycle.
- Data memory accesses use address bits [4:0]; out-of-range addresses wrap.
- Arithmetic is 32-bit two's complement; overflow wraps with no exception.
- Control signals asserted in ID: RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, Branch, Jump, ALUOp.

Test Plan:
- Reset then start, with all-zero instruction memory → PC reads 0,4,8,… one step per cycle; registers and memory unchanged; stall=0, flush=0.
- mem word 0=5; program lw $t0,0($0); addi $t1,$t0,3 → one stall (hazard pulse); $t0=5, $t1=8; PC held for exactly one cycle.
- addi $s0,$0,7; add $s1,$s0,$s0; sub $s2,$s1,$s0 (back-to-back) → via EX/MEM and MEM/WB forwarding: $s1=14, $s2=7; no stalls.
- addi $t0,$0,6; addi $t1,$0,-3; mul $t2,$t0,$t1; and/or of 12 and 10 → $t2 = −18 (0xFFFFFFEE); and = 8; or = 14.
- beq $0,$0,+2 with two following addi → one flush; the skipped instructions do not write; PC goes to the target.
- j to word 10 → flush=1 for one cycle; PC=40.
- sw $t0,4($0) with $t0=0x11223344 → mem[4..7] = 44,33,22,11; word at 0x04 reads 287454020.
- Assert reset mid-run → PC=0 immediately, without waiting for a clock edge; pipeline becomes NOPs; registers retain their values.
